// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display content multiplexer: FSM encoding,
// default display constants and a constant-evaluable clog2.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  localparam logic [31:0] DISP_DEFAULT = 32'hAA5555AA;
  localparam logic [31:0] DISP_FILL    = 32'hFFFFFFFF;

  // Number of index bits for n values; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_divider.sv
// Auto-scan timebase: a 0..SCAN_DIV-1 divider driving a wrapping modulo-NCH channel counter.
module scan_divider
  import seg7_pkg::*;
#(
  parameter int unsigned NCH      = 8,
  parameter int unsigned SCAN_DIV = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clear,
  output logic                   tick,
  output logic [clog2(NCH)-1:0]  count
);

  localparam int unsigned CntW = clog2(NCH);
  localparam int unsigned DivW = clog2(SCAN_DIV) + 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(NCH - 1);

  logic [DivW-1:0] div_q;
  logic [CntW-1:0] cnt_q;

  assign tick  = en && (div_q == DivLast);
  assign count = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (en) begin
      if (tick) begin
        div_q <= '0;
        cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_disp_mux_n.sv
// Registered 7-segment display source select with capture latch, auto-scan and freeze modes.
module seg7_disp_mux_n
  import seg7_pkg::*;
#(
  parameter int unsigned W        = 32,
  parameter int unsigned NCH      = 8,
  parameter int unsigned CTRL_W   = 6,
  parameter int unsigned SCAN_DIV = 50_000_000,
  parameter logic [W-1:0] DEFAULT = W'(DISP_DEFAULT),
  parameter logic [W-1:0] FILL    = W'(DISP_FILL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [W-1:0]          wdata,
  input  logic [CTRL_W-1:0]     ctrl,
  input  logic [NCH*W-1:0]      ch_data,
  input  logic [W-1:0]          reg_data,
  input  logic                  auto_en,
  input  logic                  freeze,
  output logic [W-1:0]          seg7_data,
  output logic [clog2(NCH)-1:0] cur_ch,
  output logic                  scan_tick
);

  localparam int unsigned CntW = clog2(NCH);
  localparam int unsigned IdxW = CTRL_W - 1;

  state_e          state_q;
  logic [W-1:0]    latch_q;
  logic [W-1:0]    seg_q;
  logic [CntW-1:0] disp_ch_q;
  logic            tick_q;

  logic            reg_view;
  logic            go_scan;
  logic            div_en;
  logic            div_clear;
  logic            div_tick;
  logic [CntW-1:0] scan_cnt;
  logic [IdxW-1:0] idx;
  logic [W-1:0]    src;

  // Slice 0 is replaced by the capture latch.
  logic unused_ch0;
  assign unused_ch0 = ^ch_data[W-1:0];

  assign reg_view  = ctrl[CTRL_W-1];
  assign go_scan   = auto_en & ~reg_view;
  assign div_clear = (state_q == ST_MANUAL) & go_scan & ~freeze;
  assign div_en    = (state_q == ST_SCAN) & go_scan & ~freeze;

  scan_divider #(
    .NCH      (NCH),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_en),
    .clear (div_clear),
    .tick  (div_tick),
    .count (scan_cnt)
  );

  always_comb begin
    idx = ctrl[IdxW-1:0];
    if (state_q == ST_SCAN) idx = IdxW'(scan_cnt);
  end

  always_comb begin
    src = FILL;
    if (reg_view) begin
      src = reg_data;
    end else if (idx == '0) begin
      src = latch_q;
    end else begin
      for (int unsigned k = 1; k < NCH; k++) begin
        if (32'(idx) == k) src = ch_data[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      latch_q <= DEFAULT;
    end else if (we) begin
      latch_q <= wdata;
    end
  end

  // Priority freeze > reg-view > auto_en collapses every state's exits to one expression;
  // the MANUAL->SCAN divider restart is handled by div_clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_MANUAL;
      seg_q     <= DEFAULT;
      disp_ch_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= div_tick;
      if (state_q != ST_HOLD) begin
        seg_q     <= src;
        disp_ch_q <= idx[CntW-1:0];
      end
      if (freeze) begin
        state_q <= ST_HOLD;
      end else if (go_scan) begin
        state_q <= ST_SCAN;
      end else begin
        state_q <= ST_MANUAL;
      end
    end
  end

  assign seg7_data = seg_q;
  assign scan_tick = tick_q;
  // Outside SCAN, report the channel whose word is held in seg7_data.
  assign cur_ch    = (state_q == ST_SCAN) ? scan_cnt : disp_ch_q;

endmodule

// File: tb/tb_seg7_disp_mux_n.sv
// Self-checking bench for seg7_disp_mux_n: directed tables and sequences plus random
// stimulus against a cycle-level behavioural model.
module tb_seg7_disp_mux_n;

  localparam int W        = 32;
  localparam int NCH      = 6;
  localparam int CTRL_W   = 6;
  localparam int SCAN_DIV = 4;
  localparam int CNT_W    = 3;
  localparam logic [31:0] DEF  = 32'hAA5555AA;
  localparam logic [31:0] FILL = 32'hFFFFFFFF;
  localparam int M_MAN = 0, M_SCAN = 1, M_HOLD = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              we;
  logic [W-1:0]      wdata;
  logic [CTRL_W-1:0] ctrl;
  logic [NCH*W-1:0]  ch_data;
  logic [W-1:0]      reg_data;
  logic              auto_en;
  logic              freeze;
  logic [W-1:0]      seg7_data;
  logic [CNT_W-1:0]  cur_ch;
  logic              scan_tick;

  seg7_disp_mux_n #(
    .W        (W),
    .NCH      (NCH),
    .CTRL_W   (CTRL_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .wdata     (wdata),
    .ctrl      (ctrl),
    .ch_data   (ch_data),
    .reg_data  (reg_data),
    .auto_en   (auto_en),
    .freeze    (freeze),
    .seg7_data (seg7_data),
    .cur_ch    (cur_ch),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model state
  int          m_st, m_div, m_cnt, m_disp, m_tick;
  logic [31:0] m_latch, m_seg;

  typedef struct {
    logic [5:0]  ctrl;
    logic [31:0] rdata;
    logic [31:0] exp_seg;
    logic [2:0]  exp_cur;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int idx;
    logic [31:0] v;
    bit go;
    if (!rst_n) begin
      m_latch = DEF; m_seg = DEF; m_st = M_MAN;
      m_div = 0; m_cnt = 0; m_disp = 0; m_tick = 0;
      return;
    end
    go  = auto_en && !ctrl[CTRL_W-1];
    idx = (m_st == M_SCAN) ? m_cnt : int'(ctrl[CTRL_W-2:0]);
    if (ctrl[CTRL_W-1]) v = reg_data;
    else if (idx == 0) v = m_latch;
    else if (idx < NCH) v = ch_data[idx*W +: W];
    else v = FILL;
    m_tick = 0;
    if (m_st != M_HOLD) begin
      m_seg  = v;
      m_disp = idx % (1 << CNT_W);
    end
    if (freeze) m_st = M_HOLD;
    else if (!go) m_st = M_MAN;
    else if (m_st == M_MAN) begin
      m_st = M_SCAN; m_div = 0; m_cnt = 0;
    end else if (m_st == M_HOLD) m_st = M_SCAN;
    else begin
      m_div = (m_div + 1) % SCAN_DIV;
      if (m_div == 0) begin
        m_cnt  = (m_cnt + 1) % NCH;
        m_tick = 1;
      end
    end
    if (we) m_latch = wdata;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [31:0] chval(input int k);
    return (k == 0) ? 32'hCAFEF00D : 32'h1000_0000 + 32'(k);
  endfunction

  initial begin
    vecs[0] = '{6'd3,       32'h0,        32'h12345678, 3'd3};
    vecs[1] = '{6'd7,       32'h0,        FILL,         3'd7};
    vecs[2] = '{6'b100000,  32'hDEADBEEF, 32'hDEADBEEF, 3'd0};
    vecs[3] = '{6'd0,       32'h0,        DEF,          3'd0};
    vecs[4] = '{6'd5,       32'h0,        32'h55550005, 3'd5};
    vecs[5] = '{6'd6,       32'h0,        FILL,         3'd6};
    vecs[6] = '{6'd31,      32'h0,        FILL,         3'd7};
    vecs[7] = '{6'b100011,  32'h01234567, 32'h01234567, 3'd3};
    vecs[8] = '{6'd1,       32'h0,        32'h10000001, 3'd1};

    // Reset with garbage inputs
    rst_n = 1'b0; we = 1'b1; wdata = 32'h1357_9BDF; ctrl = 6'h1F;
    reg_data = 32'h2468_ACE0; auto_en = 1'b1; freeze = 1'b0;
    ch_data = '0;
    for (int k = 1; k < NCH; k++) ch_data[k*W +: W] = chval(k);
    cyc();
    cyc();
    chk("reset_seg", seg7_data, DEF);
    chk("reset_cur", cur_ch, 0);
    chk("reset_tick", scan_tick, 0);

    // Manual select table
    rst_n = 1'b1; we = 1'b0; auto_en = 1'b0;
    ch_data[3*W +: W] = 32'h12345678;
    ch_data[5*W +: W] = 32'h55550005;
    for (int i = 0; i < 9; i++) begin
      ctrl = vecs[i].ctrl;
      reg_data = vecs[i].rdata;
      cyc();
      chk($sformatf("manual_seg[%0d]", i), seg7_data, vecs[i].exp_seg);
      chk($sformatf("manual_cur[%0d]", i), cur_ch, vecs[i].exp_cur);
    end
    for (int k = 1; k < NCH; k++) ch_data[k*W +: W] = chval(k);

    // Capture latch ordering
    ctrl = 6'd0; we = 1'b1; wdata = 32'hCAFEF00D;
    cyc();
    chk("capture_t1", seg7_data, DEF);
    we = 1'b0; wdata = 32'h0;
    cyc();
    chk("capture_t2", seg7_data, 32'hCAFEF00D);
    cyc();
    chk("capture_hold", seg7_data, 32'hCAFEF00D);

    // Auto-scan
    auto_en = 1'b1;
    cyc();
    chk("scan_start_cur", cur_ch, 0);
    chk("scan_start_tick", scan_tick, 0);
    for (int s = 0; s < NCH; s++) begin
      for (int j = 0; j < SCAN_DIV; j++) begin
        cyc();
        if (j < SCAN_DIV - 1) begin
          chk($sformatf("scan_cur[%0d.%0d]", s, j), cur_ch, s);
          chk($sformatf("scan_notick[%0d.%0d]", s, j), scan_tick, 0);
          if (j == 0) chk($sformatf("scan_seg[%0d]", s), seg7_data, chval(s));
        end else begin
          chk($sformatf("scan_step_cur[%0d]", s), cur_ch, (s + 1) % NCH);
          chk($sformatf("scan_step_tick[%0d]", s), scan_tick, 1);
        end
      end
    end

    // Freeze at cur_ch=2, divider=1
    repeat (9) cyc();
    chk("pre_freeze_cur", cur_ch, 2);
    chk("pre_freeze_seg", seg7_data, chval(2));
    freeze = 1'b1; we = 1'b1; wdata = 32'h0BADC0DE;
    for (int i = 0; i < 10; i++) begin
      cyc();
      we = 1'b0;
      chk($sformatf("freeze_seg[%0d]", i), seg7_data, chval(2));
      chk($sformatf("freeze_cur[%0d]", i), cur_ch, 2);
      chk($sformatf("freeze_tick[%0d]", i), scan_tick, 0);
    end
    freeze = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("resume_notick[%0d]", i), scan_tick, 0);
    end
    cyc();
    chk("resume_tick", scan_tick, 1);
    chk("resume_cur", cur_ch, 3);

    // Reg-view beats auto_en
    ctrl = 6'b100010; reg_data = 32'h5A5A1234;
    cyc();
    chk("prio_seg0", seg7_data, 32'h5A5A1234);
    cyc();
    chk("prio_seg1", seg7_data, 32'h5A5A1234);
    chk("prio_cur", cur_ch, 2);
    chk("prio_tick", scan_tick, 0);

    // Latch written during freeze; freeze and we together
    ctrl = 6'd0; auto_en = 1'b0;
    cyc();
    chk("latch_in_freeze", seg7_data, 32'h0BADC0DE);
    freeze = 1'b1; we = 1'b1; wdata = 32'h600DF00D;
    cyc();
    chk("fz_we_seg0", seg7_data, 32'h0BADC0DE);
    we = 1'b0;
    cyc();
    chk("fz_we_seg1", seg7_data, 32'h0BADC0DE);
    freeze = 1'b0;
    cyc();
    chk("fz_release_seg", seg7_data, 32'h0BADC0DE);
    cyc();
    chk("fz_new_latch", seg7_data, 32'h600DF00D);

    // Reset mid-scan
    auto_en = 1'b1;
    repeat (6) cyc();
    rst_n = 1'b0;
    cyc();
    chk("midscan_rst_seg", seg7_data, DEF);
    chk("midscan_rst_cur", cur_ch, 0);
    chk("midscan_rst_tick", scan_tick, 0);
    rst_n = 1'b1;

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      we = ($urandom_range(0, 3) == 0);
      wdata = $urandom;
      reg_data = $urandom;
      if ($urandom_range(0, 7) == 0) ctrl = 6'($urandom);
      else if ($urandom_range(0, 7) == 0) ctrl = {1'b0, 5'($urandom_range(0, 7))};
      if ($urandom_range(0, 31) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 15) == 0) freeze = ~freeze;
      if ($urandom_range(0, 63) == 0) begin
        for (int k = 1; k < NCH; k++) ch_data[k*W +: W] = $urandom;
      end
      cyc();
      chk($sformatf("rand_seg[%0d]", i), seg7_data, m_seg);
      chk($sformatf("rand_cur[%0d]", i), cur_ch, (m_st == M_SCAN) ? m_cnt : m_disp);
      chk($sformatf("rand_tick[%0d]", i), scan_tick, m_tick);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
